// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MIPS MEM pipeline stage (EX/MEM register, byte-addressable
// data memory, MEM/WB register) with parametrised depth and access latency.
//
// Ports:
//   CLK, RESET (async, active low)
//   EX_*           EX/MEM inputs (WB ctrl, read/write req, opcode, addr/ALU
//                  result, store data, rd, PC+4)
//   MEM_STALL      combinational; upstream must hold EX_* while high
//   WB*, WB_PC_4   MEM/WB register outputs
//   MEM_EXCEPTION  one-cycle pulse for a misaligned access
//
// Build option: define MEM_ALIGN_CHECK_EN to trap misaligned accesses
// (squash + MEM_EXCEPTION). Without it, addresses are force-aligned to the
// access size and MEM_EXCEPTION stays 0.
module mem_stage_unit #(
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  EX_WB,
  input  logic        EX_MEMREAD,
  input  logic        EX_MEMWRITE,
  input  logic [5:0]  EX_Opcode,
  input  logic [31:0] EX_ALU_RESULT,
  input  logic [31:0] EX_RT_DATA,
  input  logic [4:0]  EX_RD,
  input  logic [31:0] EX_PC_4,
  output logic        MEM_STALL,
  output logic [2:0]  WB,
  output logic [31:0] WB_ALU_RESULT,
  output logic [31:0] WB_RD_Data,
  output logic [4:0]  WB_RD,
  output logic [31:0] WB_PC_4,
  output logic        MEM_EXCEPTION
);
  localparam int         DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LAST  = 4'(MEM_LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  // EX/MEM register
  logic [2:0]  xm_wb;
  logic        xm_rd, xm_wr;
  logic [5:0]  xm_op;
  logic [31:0] xm_alu, xm_rt, xm_pc4;
  logic [4:0]  xm_rdi;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      xm_wb <= '0; xm_rd <= 1'b0; xm_wr <= 1'b0; xm_op <= '0;
      xm_alu <= '0; xm_rt <= '0; xm_pc4 <= '0; xm_rdi <= '0;
    end else if (!MEM_STALL) begin
      xm_wb <= EX_WB; xm_rd <= EX_MEMREAD; xm_wr <= EX_MEMWRITE; xm_op <= EX_Opcode;
      xm_alu <= EX_ALU_RESULT; xm_rt <= EX_RT_DATA; xm_pc4 <= EX_PC_4; xm_rdi <= EX_RD;
    end
  end

  // access size decode
  logic is_byte, is_half, is_sgn;
  always_comb begin
    is_byte = (xm_op == 6'b100000) || (xm_op == 6'b100100) || (xm_op == 6'b101000);
    is_half = (xm_op == 6'b100001) || (xm_op == 6'b100101) || (xm_op == 6'b101001);
    is_sgn  = (xm_op == 6'b100000) || (xm_op == 6'b100001);
  end

  logic                 acc, mis, mem_op;
  logic [ADDR_BITS+1:0] addr;
  assign acc = xm_rd | xm_wr;
`ifdef MEM_ALIGN_CHECK_EN
  assign mis  = acc && ((is_half && xm_alu[0]) ||
                        (!is_byte && !is_half && (xm_alu[1:0] != 2'b00)));
  assign addr = xm_alu[ADDR_BITS+1:0];
`else
  assign mis  = 1'b0;
  assign addr = is_byte ? xm_alu[ADDR_BITS+1:0] :
                is_half ? {xm_alu[ADDR_BITS+1:1], 1'b0} :
                          {xm_alu[ADDR_BITS+1:2], 2'b00};
`endif
  assign mem_op = acc && !mis;

  // latency FSM
  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       done;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (mem_op && MEM_LATENCY > 1) begin state_nx = WAIT; cnt_nx = 4'd1; end
      WAIT: if (cnt == LAST) begin state_nx = IDLE; cnt_nx = '0; end
            else cnt_nx = cnt + 4'd1;
      default: begin state_nx = IDLE; cnt_nx = '0; end
    endcase
  end

  always_comb begin
    MEM_STALL = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (mem_op) begin
              if (MEM_LATENCY == 1) done = 1'b1;
              else MEM_STALL = 1'b1;
            end
      WAIT: if (cnt == LAST) done = 1'b1;
            else MEM_STALL = 1'b1;
      default: ;
    endcase
  end

  // byte-lane memory: one RAM per lane so stores touch only enabled lanes
  logic [ADDR_BITS-1:0] widx;
  logic [1:0]           boff;
  logic [3:0]           be;
  logic [31:0]          wdata, rd_word, sh_word, ld;
  logic                 we;

  assign widx = addr[ADDR_BITS+1:2];
  assign boff = addr[1:0];
  assign we   = done && xm_wr && mem_op;

  always_comb begin
    if (is_byte) begin
      be = 4'b0001 << boff;   wdata = {4{xm_rt[7:0]}};
    end else if (is_half) begin
      be = boff[1] ? 4'b1100 : 4'b0011; wdata = {2{xm_rt[15:0]}};
    end else begin
      be = 4'b1111;           wdata = xm_rt;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] ram [DEPTH];
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      end else if (we && be[b]) begin
        ram[widx] <= wdata[8*b +: 8];
      end
    end
    assign rd_word[8*b +: 8] = ram[widx];
  end

  // load extraction; simultaneous read+write acts as a store and returns 0
  assign sh_word = rd_word >> {boff, 3'b000};
  always_comb begin
    if (!xm_rd || xm_wr) ld = '0;
    else if (is_byte)    ld = {{24{is_sgn & sh_word[7]}},  sh_word[7:0]};
    else if (is_half)    ld = {{16{is_sgn & sh_word[15]}}, sh_word[15:0]};
    else                 ld = rd_word;
  end

  // MEM/WB register; a stalled cycle emits a bubble
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      WB <= '0; WB_ALU_RESULT <= '0; WB_RD_Data <= '0;
      WB_RD <= '0; WB_PC_4 <= '0; MEM_EXCEPTION <= 1'b0;
    end else begin
      WB_ALU_RESULT <= xm_alu;
      WB_RD_Data    <= ld;
      WB_PC_4       <= xm_pc4;
      if (MEM_STALL) begin
        WB <= '0; WB_RD <= '0; MEM_EXCEPTION <= 1'b0;
      end else begin
        WB            <= mis ? 3'b000 : xm_wb;
        WB_RD         <= xm_rdi;
        MEM_EXCEPTION <= mis;
      end
    end
  end
endmodule
